// File: rtl/pat_pkg.sv
// Shared definitions for the pat processor sequencing path.
// Provides op encodings, fault bit indices and the sequencer state type.
package pat_pkg;

    localparam int unsigned OP_WIDTH    = 3;
    localparam int unsigned FAULT_WIDTH = 2;

    localparam logic [OP_WIDTH-1:0] OP_NEXT = 3'd0;
    localparam logic [OP_WIDTH-1:0] OP_BF   = 3'd1;
    localparam logic [OP_WIDTH-1:0] OP_BB   = 3'd2;
    localparam logic [OP_WIDTH-1:0] OP_CALL = 3'd3;
    localparam logic [OP_WIDTH-1:0] OP_RET  = 3'd4;
    localparam logic [OP_WIDTH-1:0] OP_HALT = 3'd5;

    localparam int unsigned FAULT_OVF = 0;
    localparam int unsigned FAULT_UNF = 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_e;

endpackage

// File: rtl/pat_call_stack.sv
// Parametrised LIFO holding return addresses.
// Ports: clk, rst_n (sync, active-low), push/pop requests, push_data,
//        depth (valid entries), top (registered top entry, 0 when empty),
//        full_c/empty_c (combinational status from depth).
// Push on full and pop on empty are ignored; policy lives in the caller.
module pat_call_stack #(
    parameter int unsigned DATA_WIDTH  = 10,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned DEPTH_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_WIDTH-1:0]  push_data,
    output logic [DEPTH_WIDTH-1:0] depth,
    output logic [DATA_WIDTH-1:0]  top,
    output logic                   full_c,
    output logic                   empty_c
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [DEPTH_WIDTH-1:0] depth_q, depth_d;
    logic [DATA_WIDTH-1:0]  top_q, top_d;
    logic                   do_push, do_pop;

    assign full_c  = (depth_q == DEPTH_WIDTH'(DEPTH));
    assign empty_c = (depth_q == '0);
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c && !push;

    // Next depth and top; top after a pop is the entry below the old top.
    always_comb begin
        depth_d = depth_q;
        top_d   = top_q;
        if (do_push) begin
            depth_d = depth_q + DEPTH_WIDTH'(1);
            top_d   = push_data;
        end else if (do_pop) begin
            depth_d = depth_q - DEPTH_WIDTH'(1);
            if (depth_q > DEPTH_WIDTH'(1)) begin
                top_d = mem_q[IDX_W'(depth_q - DEPTH_WIDTH'(2))];
            end else begin
                top_d = '0;
            end
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[IDX_W'(depth_q)] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            depth_q <= '0;
            top_q   <= '0;
        end else begin
            depth_q <= depth_d;
            top_q   <= top_d;
        end
    end

    assign depth = depth_q;
    assign top   = top_q;

endmodule

// File: rtl/pat_sequencer.sv
// Program sequencer: owns the PC and call stack, executes one sequencing
// op per advancing cycle, halts on HALT op or stack over/underflow.
// Ports: clk, rst_n (sync, active-low), advance (op valid), op, cond_ok,
//        offset, resume; outputs pc, depth, stack_top, halted, fault.
module pat_sequencer
    import pat_pkg::*;
#(
    parameter int unsigned I_ADR_WIDTH  = 10,
    parameter int unsigned OFFSET_WIDTH = 8,
    parameter int unsigned STACK_DEPTH  = 8,
    parameter int unsigned DEPTH_WIDTH  = 4,
    parameter int unsigned RESET_PC     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    advance,
    input  logic [OP_WIDTH-1:0]     op,
    input  logic                    cond_ok,
    input  logic [OFFSET_WIDTH-1:0] offset,
    input  logic                    resume,
    output logic [I_ADR_WIDTH-1:0]  pc,
    output logic [DEPTH_WIDTH-1:0]  depth,
    output logic [I_ADR_WIDTH-1:0]  stack_top,
    output logic                    halted,
    output logic [FAULT_WIDTH-1:0]  fault
);

    seq_state_e             state_q, state_d;
    logic [I_ADR_WIDTH-1:0] pc_q, pc_d;
    logic [FAULT_WIDTH-1:0] fault_q, fault_d;
    logic                   push, pop;
    logic [I_ADR_WIDTH-1:0] pc_inc, offset_ext;
    logic                   stk_full, stk_empty;

    assign pc_inc     = pc_q + I_ADR_WIDTH'(1);
    assign offset_ext = I_ADR_WIDTH'(offset);

    pat_call_stack #(
        .DATA_WIDTH  (I_ADR_WIDTH),
        .DEPTH       (STACK_DEPTH),
        .DEPTH_WIDTH (DEPTH_WIDTH)
    ) u_call_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .depth     (depth),
        .top       (stack_top),
        .full_c    (stk_full),
        .empty_c   (stk_empty)
    );

    // Next-state / PC / fault decode; resume beats any op in the same cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (resume) begin
            state_d = ST_RUN;
            fault_d = '0;
        end else if (state_q == ST_RUN && advance) begin
            if (!cond_ok) begin
                pc_d = pc_inc;
            end else begin
                case (op)
                    OP_BF: pc_d = pc_q + offset_ext;
                    OP_BB: pc_d = pc_q - offset_ext;
                    OP_CALL: begin
                        if (stk_full) begin
                            fault_d[FAULT_OVF] = 1'b1;
                            state_d            = ST_HALT;
                        end else begin
                            push = 1'b1;
                            pc_d = pc_q + offset_ext;
                        end
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            fault_d[FAULT_UNF] = 1'b1;
                            state_d            = ST_HALT;
                        end else begin
                            pop  = 1'b1;
                            pc_d = stack_top;
                        end
                    end
                    OP_HALT: state_d = ST_HALT;
                    default: pc_d = pc_inc;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= I_ADR_WIDTH'(RESET_PC);
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    assign pc     = pc_q;
    assign halted = (state_q == ST_HALT);
    assign fault  = fault_q;

endmodule
